// File: rtl/abro_event_arbiter.sv
// abro_event_arbiter: NUM_CH independent ABRO sequences sharing one output
// port. Each channel completes once it has seen both A and B since its last
// restart. A round-robin arbiter moves one completed channel at a time into
// a single-entry output slot that is drained by a valid/ready handshake.
module abro_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     A,
    input  logic [NUM_CH-1:0]     B,
    input  logic [NUM_CH-1:0]     R,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [CH_W-1:0]       out_ch,
    output logic [NUM_CH-1:0]     pending,
    output logic [NUM_CH-1:0]     overrun,
    output logic [2*NUM_CH-1:0]   CurrentState
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        GOT_B = 2'b10,
        DONE  = 2'b11
    } ch_state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [NUM_CH-1:0] overrun_d;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   winner;
    logic              found;
    logic              slot_free;
    logic              load;

    // Expose the channel state registers and derive the per-channel request.
    always_comb begin
        CurrentState = '0;
        pending      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            CurrentState[2*i +: 2] = state_q[i];
            pending[i]             = (state_q[i] == DONE);
        end
    end

    // Circular search for the first DONE channel after the last winner.
    always_comb begin
        int              sum;
        logic [CH_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            sum = int'(last_grant) + off;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            idx = CH_W'(sum);
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The slot accepts a new completion when empty or draining this cycle.
    always_comb begin
        slot_free = !out_valid || out_ready;
        load      = slot_free && found;
        grant     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = load && (winner == CH_W'(i));
        end
    end

    // Per-channel next state: restart beats load, load beats A/B events.
    always_comb begin
        overrun_d = overrun;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            if (R[i]) begin
                state_d[i]   = IDLE;
                overrun_d[i] = 1'b0;
            end else if (grant[i]) begin
                state_d[i] = IDLE;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (A[i] && B[i]) begin
                            state_d[i] = DONE;
                        end else if (A[i]) begin
                            state_d[i] = GOT_A;
                        end else if (B[i]) begin
                            state_d[i] = GOT_B;
                        end
                    end
                    GOT_A: begin
                        if (B[i]) begin
                            state_d[i] = DONE;
                        end
                    end
                    GOT_B: begin
                        if (A[i]) begin
                            state_d[i] = DONE;
                        end
                    end
                    DONE: begin
                        if (A[i] || B[i]) begin
                            overrun_d[i] = 1'b1;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    // Channel state and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
            end
            overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            overrun <= overrun_d;
        end
    end

    // Output slot: load a winner, or empty it after a transfer with no requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            last_grant <= LAST_CH;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_ch     <= winner;
            last_grant <= winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_abro_event_arbiter.sv
// tb_abro_event_arbiter: directed stimulus with a completion scoreboard.
// Expected channel indices are queued when stimulus is issued; a monitor
// pops and compares one entry for every accepted transfer.
module tb_abro_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] A, B, R;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_ch;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [7:0] CurrentState;

    int check_count = 0;
    int error_count = 0;
    int sb[$];

    abro_event_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .R            (R),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .pending      (pending),
        .overrun      (overrun),
        .CurrentState (CurrentState)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then step just past the next rising edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] r, input logic rdy,
                                 input logic rst);
        A         = a;
        B         = b;
        R         = r;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        #2;
    endtask

    // Monitor: a transfer is valid & ready without reset at the coming edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL xfer_unexpected: actual=ch%0d required=none", out_ch);
            end else begin
                checkOutput("xfer_ch", 32'(out_ch), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        A = '0; B = '0; R = '0; out_ready = 1'b0; reset = 1'b1;

        // Reset values
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("rst_state", 32'(CurrentState), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_ch", 32'(out_ch), 32'h0);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);

        // Simultaneous A/B on channel 0
        $display("[TB] single completion on channel 0");
        sb.push_back(0);
        applyStimulus(4'b0001, 4'b0001, 4'h0, 1'b1, 1'b0);
        checkOutput("t1_done", 32'(CurrentState[1:0]), 32'h3);
        checkOutput("t1_valid_early", 32'(out_valid), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t1_valid", 32'(out_valid), 32'h1);
        checkOutput("t1_ch", 32'(out_ch), 32'h0);
        checkOutput("t1_idle", 32'(CurrentState), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t1_drained", 32'(out_valid), 32'h0);

        // Ordered A then B on channel 2
        $display("[TB] ordered events on channel 2");
        applyStimulus(4'b0100, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_got_a0", 32'(CurrentState), 32'h10);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_got_a1", 32'(CurrentState), 32'h10);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_got_a2", 32'(CurrentState), 32'h10);
        sb.push_back(2);
        applyStimulus(4'h0, 4'b0100, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_done", 32'(CurrentState[5:4]), 32'h3);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_valid", 32'(out_valid), 32'h1);
        checkOutput("t2_ch", 32'(out_ch), 32'h2);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_drained", 32'(out_valid), 32'h0);

        // All channels complete together behind a stalled consumer
        $display("[TB] four simultaneous completions");
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
        applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        checkOutput("t3_pending_all", 32'(pending), 32'hF);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
            checkOutput("t3_hold_valid", 32'(out_valid), 32'h1);
            checkOutput("t3_hold_ch", 32'(out_ch), 32'h0);
            checkOutput("t3_hold_pending", 32'(pending), 32'hE);
        end
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t3_ch1", 32'(out_ch), 32'h1);
        checkOutput("t3_pend1", 32'(pending), 32'hC);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t3_ch2", 32'(out_ch), 32'h2);
        checkOutput("t3_pend2", 32'(pending), 32'h8);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t3_ch3", 32'(out_ch), 32'h3);
        checkOutput("t3_pend3", 32'(pending), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t3_drained", 32'(out_valid), 32'h0);

        // Channels 0 and 1 re-completing every cycle must alternate
        $display("[TB] round-robin between channels 0 and 1");
        for (int k = 0; k < 4; k++) begin
            sb.push_back(0);
            sb.push_back(1);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0011, 4'b0011, 4'h0, 1'b1, 1'b0);
        end
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t4_drained", 32'(out_valid), 32'h0);
        checkOutput("t4_overrun", 32'(overrun), 32'h2);

        // Overrun on a waiting channel, then restart it
        $display("[TB] overrun and restart on channel 3");
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'b1010, 4'b1010, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5_slot_ch", 32'(out_ch), 32'h1);
        checkOutput("t5_pending", 32'(pending), 32'h8);
        sb.push_back(1);
        applyStimulus(4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("t5_overrun_set", 32'(overrun), 32'h8);
        checkOutput("t5_still_done", 32'(CurrentState[7:6]), 32'h3);
        applyStimulus(4'h0, 4'h0, 4'b1000, 1'b0, 1'b0);
        checkOutput("t5_restart_state", 32'(CurrentState), 32'h0);
        checkOutput("t5_overrun_clr", 32'(overrun), 32'h0);
        checkOutput("t5_offer_valid", 32'(out_valid), 32'h1);
        checkOutput("t5_offer_ch", 32'(out_ch), 32'h1);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t5_drained", 32'(out_valid), 32'h0);

        // Reset during an accepted offer drops it without a transfer
        $display("[TB] reset during transfer");
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("t6_valid", 32'(out_valid), 32'h1);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        checkOutput("t6_valid_rst", 32'(out_valid), 32'h0);
        checkOutput("t6_state_rst", 32'(CurrentState), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t6_idle_valid", 32'(out_valid), 32'h0);

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
